// File: rtl/count_link_pkg.sv
// Shared types and helpers for the UART count-frame receiver.
// Used by uart_rx_byte and count_frame_rx (checksum option: COUNT_FRAME_CHECKSUM_EN).
package count_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         BITS_PER_FRAME = 10;

    typedef enum logic [1:0] {P_HUNT, P_C1, P_C2, P_CSUM} parse_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [3:0] sat_nib(input logic [7:0] v);
        return (v > 8'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, half-bit start check, mid-bit sampling.
// byte_ok_o / byte_ferr_o are single-cycle strobes on the stop-bit sample cycle.
module uart_rx_byte
    import count_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_ok_o,
    output logic       byte_ferr_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          brk_q, brk_d;

    assign rx_s   = sync_q[1];
    assign data_o = sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        sh_d        = sh_q;
        brk_d       = brk_q;
        byte_ok_o   = 1'b0;
        byte_ferr_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // After a bad stop bit, hold here until the line returns high
                // so a low line is not mistaken for a new start bit.
                if (brk_q) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        brk_d   = 1'b0;
                        state_d = RX_IDLE;
                    end
                end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_ok_o = 1'b1;
                        state_d   = RX_IDLE;
                    end else begin
                        byte_ferr_o = 1'b1;
                        brk_d       = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/count_frame_rx.sv
// Vehicle-count frame parser (SYNC, C1, C2[, CK]) with gap timeout and link-stale timer.
// Define COUNT_FRAME_CHECKSUM_EN to require the XOR checksum byte.
module count_frame_rx
    import count_link_pkg::*;
#(
    parameter int         CLK_HZ    = 50000000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         GAP_BYTES = 2,
    parameter int         STALE_MS  = 3000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] count1,
    output logic [3:0] count2,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       link_ok
);

    localparam int CPB     = CLK_HZ / BAUD;
    localparam int GAP_CYC = GAP_BYTES * BITS_PER_FRAME * CPB;
    localparam int MS_DIV  = CLK_HZ / 1000;
    localparam int GW      = $clog2(GAP_CYC + 1);
    localparam int PW      = $clog2(MS_DIV + 1);
    localparam int SW      = $clog2(STALE_MS + 1);

    logic [1:0]   rst_sync_q;
    logic         rst_n;
    logic [7:0]   byte_data;
    logic         byte_ok, byte_ferr;
    parse_state_e state_q, state_d;
    logic [7:0]   c1_q, c1_d, c2_q, c2_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] ms_q, ms_d;
    logic [SW-1:0] stale_q, stale_d;
    logic [3:0]   count1_q, count2_q;
    logic         fv_q, fe_q, link_q, link_d;
    logic         commit, err, ms_tick;

    // Assert asynchronously, release synchronously.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk_i       (clk_50MHz),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .data_o      (byte_data),
        .byte_ok_o   (byte_ok),
        .byte_ferr_o (byte_ferr)
    );

    always_comb begin
        state_d = state_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        gap_d   = (state_q == P_HUNT || byte_ok) ? '0 : gap_q + 1'b1;
        commit  = 1'b0;
        err     = 1'b0;
        if (byte_ferr) begin
            err     = 1'b1;
            state_d = P_HUNT;
        end else if (byte_ok) begin
            case (state_q)
                P_HUNT: if (byte_data == SYNC_BYTE) state_d = P_C1;
                P_C1: begin
                    c1_d    = byte_data;
                    state_d = P_C2;
                end
                P_C2: begin
                    c2_d = byte_data;
`ifdef COUNT_FRAME_CHECKSUM_EN
                    state_d = P_CSUM;
`else
                    commit  = 1'b1;
                    state_d = P_HUNT;
`endif
                end
`ifdef COUNT_FRAME_CHECKSUM_EN
                P_CSUM: begin
                    state_d = P_HUNT;
                    if (byte_data == (c1_q ^ c2_q)) commit = 1'b1;
                    else                            err    = 1'b1;
                end
`endif
                default: state_d = P_HUNT;
            endcase
        end else if (state_q != P_HUNT && gap_q == GW'(GAP_CYC - 1)) begin
            err     = 1'b1;
            state_d = P_HUNT;
        end
    end

    always_comb begin
        ms_tick = (ms_q == PW'(MS_DIV - 1));
        ms_d    = ms_tick ? '0 : ms_q + 1'b1;
        stale_d = stale_q;
        link_d  = link_q;
        if (commit) begin
            stale_d = '0;
            link_d  = 1'b1;
        end else begin
            if (ms_tick && stale_q != SW'(STALE_MS)) stale_d = stale_q + 1'b1;
            if (stale_q == SW'(STALE_MS))            link_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= P_HUNT;
            c1_q     <= '0;
            c2_q     <= '0;
            gap_q    <= '0;
            ms_q     <= '0;
            stale_q  <= '0;
            count1_q <= '0;
            count2_q <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            link_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            gap_q   <= gap_d;
            ms_q    <= ms_d;
            stale_q <= stale_d;
            fv_q    <= commit;
            fe_q    <= err;
            link_q  <= link_d;
            if (commit) begin
                count1_q <= sat_nib(c1_d);
                count2_q <= sat_nib(c2_d);
            end
        end
    end

    assign count1      = count1_q;
    assign count2      = count2_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign link_ok     = link_q;

endmodule

// File: tb/tb_count_frame_rx.sv
// Bench for count_frame_rx: directed frames plus random byte streams against a byte-level model.
// Follows COUNT_FRAME_CHECKSUM_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_count_frame_rx;

    localparam int CLK_HZ    = 16000;
    localparam int BAUD      = 2000;
    localparam int CPB       = CLK_HZ / BAUD;
    localparam int GAP_BYTES = 2;
    localparam int STALE_MS  = 20;
    localparam int MS_CYC    = CLK_HZ / 1000;
    localparam int GAP_CYC   = GAP_BYTES * 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] count1, count2;
    logic       frame_valid, frame_err, link_ok;

    count_frame_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC_BYTE(8'hA5),
        .GAP_BYTES(GAP_BYTES), .STALE_MS(STALE_MS)
    ) dut (
        .clk_50MHz(clk), .reset(reset), .rx(rx),
        .count1(count1), .count2(count2),
        .frame_valid(frame_valid), .frame_err(frame_err), .link_ok(link_ok)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int nv = 0, ne = 0, both = 0;

    always @(negedge clk) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
        if (frame_valid && frame_err) both++;
    end

    // byte-level reference: position in frame, raw fields, expected counts and pulse totals
    int         pos = 0;
    logic [7:0] r1, r2;
    int         m_c1 = 0, m_c2 = 0, m_nv = 0, m_ne = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic m_commit();
        m_c1 = sat(int'(r1));
        m_c2 = sat(int'(r2));
        m_nv++;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_ne++;
            pos = 0;
        end else begin
            case (pos)
                0: if (b == 8'hA5) pos = 1;
                1: begin r1 = b; pos = 2; end
                2: begin
                    r2 = b;
`ifdef COUNT_FRAME_CHECKSUM_EN
                    pos = 3;
`else
                    m_commit();
                    pos = 0;
`endif
                end
                default: begin
                    if (b == (r1 ^ r2)) m_commit();
                    else m_ne++;
                    pos = 0;
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b, input bit bad);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(bad ? 1'b0 : 1'b1);
        if (bad) bit_out(1'b1);
        idle($urandom_range(0, 8));
        model_byte(b, bad);
    endtask

    task automatic gap();
        idle(GAP_CYC + 80);
        if (pos != 0) begin
            m_ne++;
            pos = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
        tx(8'hA5, 1'b0);
        tx(a, 1'b0);
        tx(b, 1'b0);
`ifdef COUNT_FRAME_CHECKSUM_EN
        tx(a ^ b, 1'b0);
`endif
    endtask

    int v0, e0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_c1", int'(count1), 0);
        chk("rst_c2", int'(count2), 0);
        chk("rst_fv", int'(frame_valid), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_link", int'(link_ok), 0);
        reset = 1'b1;
        idle(10);
        chk("post_rst_link", int'(link_ok), 0);

        // good frame
        v0 = nv; e0 = ne;
        send_frame(8'h07, 8'h0C); idle(4);
        chk("good_c1", int'(count1), 7);
        chk("good_c2", int'(count2), 12);
        chk("good_fv", nv - v0, 1);
        chk("good_fe", ne - e0, 0);
        chk("good_link", int'(link_ok), 1);

        // saturation, SYNC value inside a field
        send_frame(8'hA5, 8'h03); idle(4);
        chk("sat_c1", int'(count1), 15);
        chk("sat_c2", int'(count2), 3);

        // leading junk
        v0 = nv; e0 = ne;
        tx(8'h11, 1'b0); tx(8'h22, 1'b0);
        send_frame(8'h05, 8'h06); idle(4);
        chk("junk_c1", int'(count1), 5);
        chk("junk_c2", int'(count2), 6);
        chk("junk_fe", ne - e0, 0);
        chk("junk_fv", nv - v0, 1);

        // framing error on C1
        v0 = nv; e0 = ne;
        tx(8'hA5, 1'b0); tx(8'h09, 1'b1); idle(4);
        chk("ferr_fe", ne - e0, 1);
        chk("ferr_fv", nv - v0, 0);
        chk("ferr_c1", int'(count1), 5);
        chk("ferr_c2", int'(count2), 6);
        send_frame(8'h01, 8'h02); idle(4);
        chk("ferr_next_c1", int'(count1), 1);
        chk("ferr_next_c2", int'(count2), 2);

        // gap timeout mid-frame
        v0 = nv; e0 = ne;
        tx(8'hA5, 1'b0); tx(8'h04, 1'b0);
        gap();
        chk("gap_fe", ne - e0, 1);
        chk("gap_fv", nv - v0, 0);
        send_frame(8'h0E, 8'h10); idle(4);
        chk("gap_next_c1", int'(count1), 14);
        chk("gap_next_c2", int'(count2), 15);
        chk("gap_next_link", int'(link_ok), 1);

        // bad checksum / trailing byte
        v0 = nv; e0 = ne;
        tx(8'hA5, 1'b0); tx(8'h02, 1'b0); tx(8'h03, 1'b0); tx(8'hFF, 1'b0); idle(4);
`ifdef COUNT_FRAME_CHECKSUM_EN
        chk("ck_fe", ne - e0, 1);
        chk("ck_fv", nv - v0, 0);
        chk("ck_c1", int'(count1), 14);
        chk("ck_c2", int'(count2), 15);
`else
        chk("ck_fe", ne - e0, 0);
        chk("ck_fv", nv - v0, 1);
        chk("ck_c1", int'(count1), 2);
        chk("ck_c2", int'(count2), 3);
`endif

        // stale link, counts held
        idle((STALE_MS + 2) * MS_CYC);
        chk("stale_link", int'(link_ok), 0);
        chk("stale_c1", int'(count1), m_c1);
        chk("stale_c2", int'(count2), m_c2);

        // reset in the middle of a byte
        bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_c1", int'(count1), 0);
        chk("mid_rst_c2", int'(count2), 0);
        chk("mid_rst_fv", int'(frame_valid), 0);
        chk("mid_rst_fe", int'(frame_err), 0);
        chk("mid_rst_link", int'(link_ok), 0);
        pos = 0; m_c1 = 0; m_c2 = 0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(20);
        send_frame(8'h09, 8'h03); idle(4);
        chk("after_rst_c1", int'(count1), 9);
        chk("after_rst_c2", int'(count2), 3);
        chk("after_rst_link", int'(link_ok), 1);

        // random byte streams against the model
        for (int s = 0; s < 25; s++) begin
            int nb;
            nb = $urandom_range(3, 7);
            for (int k = 0; k < nb; k++) begin
                logic [7:0] b;
                bit bad;
                b   = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                bad = ($urandom_range(0, 11) == 0);
                tx(b, bad);
                if ($urandom_range(0, 14) == 0) gap();
            end
            gap();
            chk("rnd_c1", int'(count1), m_c1);
            chk("rnd_c2", int'(count2), m_c2);
            chk("rnd_nv", nv, m_nv);
            chk("rnd_ne", ne, m_ne);
        end

        chk("fv_fe_overlap", both, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/count_frame_rx.md
Name: count_frame_rx

Overview:
- Receives per-road vehicle counts from the OpenCV host PC over a UART link. Produces the `count1`/`count2` nibbles consumed by the traffic controller state machine.
- Decodes 8N1 serial bytes and parses fixed-length frames. Holds the last good counts and flags link health.
- Sits beside the 1 Hz generator and debounce blocks at traffic_controller top level, on `clk_50MHz`.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
- SYNC_BYTE, 8'hA5, frame start marker.
- GAP_BYTES, 2, mid-frame idle limit in byte-times (10 bits each) before the parser abandons the frame.
- STALE_MS, 3000, milliseconds without a good frame before `link_ok` drops.

Ports:
- clk_50MHz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  UART line from the host, idle high, asynchronous to the clock.
- count1  output  4  last accepted main-road count.
- count2  output  4  last accepted cross-road count.
- frame_valid  output  1  one-cycle pulse when new counts are committed.
- frame_err  output  1  one-cycle pulse on framing error, checksum error or gap timeout.
- link_ok  output  1  high while a good frame arrived within the last STALE_MS.

Behaviour:
- Reset, asserted asynchronously:
  - count1 = 0, count2 = 0, frame_valid = 0, frame_err = 0, link_ok = 0.
  - Parser goes to HUNT; byte receiver goes to IDLE; all counters clear.
- Release is synchronised internally with a 2-FF chain.
- rx passes through a 2-FF synchroniser (initialised to 1) before any use.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronised rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles and re-sample. If rx = 1, treat as a glitch and return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits LSB-first, each CLKS_PER_BIT cycles apart.
  - STOP: sample one CLKS_PER_BIT later. If 1, byte_ok pulses for 1 cycle. If 0, byte_ferr pulses and the receiver waits for rx = 1 before returning to IDLE.
- Parser states: HUNT, C1, C2, CSUM (CSUM only with the optional feature).
  - HUNT: byte == SYNC_BYTE → C1; any other byte is ignored silently.
  - C1: latch byte into c1_raw → C2.
  - C2: latch c2_raw. Commit if the feature is off, else → CSUM.
  - Fields are positional: a SYNC_BYTE value inside C1/C2 is data, not resync.
- Commit:
  - Each field saturates: value > 15 gives 4'hF, otherwise the low nibble.
  - count1/count2 update on the cycle after byte_ok of the final byte.
  - frame_valid pulses that same cycle; parser returns to HUNT.
- Errors:
  - byte_ferr in any parser state → frame_err pulse, HUNT, counts unchanged.
  - Gap timeout: in C1/C2/CSUM, no byte_ok for GAP_BYTES×10×CLKS_PER_BIT cycles → frame_err pulse, HUNT.
  - frame_err and frame_valid never assert in the same cycle.
- link_ok and stale timer:
  - A ms prescaler (CLK_HZ/1000) drives a stale counter.
  - Every commit sets link_ok = 1 and clears the counter.
  - When the counter reaches STALE_MS, link_ok = 0 and the counter saturates there.
  - Counts are held, not cleared, when the link goes stale.
- Latency: frame_valid lands 1 cycle after the stop-bit sample of the last byte.

Optional Feature:
- Macro: COUNT_FRAME_CHECKSUM_EN.
- Defined: 4-byte frame SYNC, C1, C2, CK. Commit only if CK == (c1_raw ^ c2_raw). A mismatch gives a frame_err pulse, HUNT, and counts unchanged.
- Undefined: 3-byte frame with no CSUM state. A trailing byte is treated by HUNT as ordinary non-sync data.

Decomposition:
- Shared package count_link_pkg holds:
  - SYNC_BYTE default, parser state typedef (HUNT/C1/C2/CSUM), byte receiver state typedef.
  - Bits-per-frame constant 10, and a saturate-to-nibble function.
- Sub-module uart_rx_byte (synchroniser, baud timing, 8N1 framing) outputs byte data, byte_ok and byte_ferr.
- count_frame_rx contains the parser, gap timer, stale timer and output registers.

Test Plan:
- Good frame: send A5 07 0C (CK 0B with the macro) at 115200 → one frame_valid pulse, count1 = 7, count2 = 12, link_ok = 1.
- Saturation and positional sync:
  - A5 A5 03 (CK A6) → count1 = 15, count2 = 3.
  - Leading junk 11 22 before A5 05 06 (CK 03) → counts 5/6 and no frame_err.
- Framing error: stop bit forced 0 on the C1 byte → frame_err pulse, counts keep their prior values. A following good frame A5 01 02 (CK 03) commits.
- Gap timeout: send A5 04 then idle 3 byte-times → frame_err once, then HUNT. A following good frame commits normally.
- Checksum (macro on): A5 02 03 FF → frame_err, no frame_valid. Macro off: same bytes → counts 2/3, and FF is ignored.
- Reset and stale:
  - reset = 0 mid-byte → outputs 0 immediately; after release the next complete frame is decoded correctly.
  - No frames for 3000 ms after a good one → link_ok falls, counts are held.
